// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DCD/EXE/MEM/WB and drives datapath selects/enables.
// Optional retired-instruction counter enabled by defining INSTRET_CNT_EN.
module mc_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             gtz,
    input  logic             dm_ack,
    output logic             PC_Write,
    output logic             IR_Write,
    output logic [1:0]       NPCOp,
    output logic [1:0]       RegDst,
    output logic             AluSrc,
    output logic [1:0]       MemToReg,
    output logic             GPR_Write,
    output logic             DM_Write,
    output logic             dm_req,
    output logic             SignExt,
    output logic             LuiExt,
    output logic [2:0]       ALUOp,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             mem_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_bgtz, w_jal;
    logic        w_rtype, w_legal, w_timeout;
    logic        w_unused;

    logic        w_pc_write, w_ir_write, w_gpr_write, w_dm_write, w_dm_req;
    logic        w_illegal, w_mem_err;

    assign w_op     = instr[31:26];
    assign w_funct  = instr[5:0];
    assign w_unused = ^instr[25:6];

    assign w_addu  = (w_op == 6'h00) && (w_funct == 6'h21);
    assign w_subu  = (w_op == 6'h00) && (w_funct == 6'h23);
    assign w_jr    = (w_op == 6'h00) && (w_funct == 6'h08);
    assign w_ori   = (w_op == 6'h0d);
    assign w_lui   = (w_op == 6'h0f);
    assign w_lw    = (w_op == 6'h23);
    assign w_sw    = (w_op == 6'h2b);
    assign w_beq   = (w_op == 6'h04);
    assign w_bgtz  = (w_op == 6'h07);
    assign w_jal   = (w_op == 6'h03);
    assign w_rtype = w_addu | w_subu;
    assign w_legal = w_rtype | w_jr | w_ori | w_lui | w_lw | w_sw | w_beq | w_bgtz | w_jal;

    // Ack in the last allowed cycle takes priority over the abort.
    assign w_timeout = (r_state == S_MEM) && (r_wait == TO_LAST) && !dm_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= 8'd0;
        end else if ((r_state == S_MEM) && (w_next == S_MEM)) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= 8'd0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: w_next = S_DCD;
            S_DCD: begin
                if (w_jal || w_jr || !w_legal) w_next = S_FETCH;
                else                           w_next = S_EXE;
            end
            S_EXE: begin
                if (w_beq || w_bgtz)   w_next = S_FETCH;
                else if (w_lw || w_sw) w_next = S_MEM;
                else                   w_next = S_WB;
            end
            S_MEM: begin
                if (dm_ack)         w_next = w_lw ? S_WB : S_FETCH;
                else if (w_timeout) w_next = S_FETCH;
                else                w_next = S_MEM;
            end
            S_WB:    w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_gpr_write = 1'b0;
        w_dm_write  = 1'b0;
        w_dm_req    = 1'b0;
        w_illegal   = 1'b0;
        w_mem_err   = 1'b0;
        NPCOp       = 2'b00;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        AluSrc      = 1'b0;
        SignExt     = 1'b0;
        LuiExt      = 1'b0;
        ALUOp       = 3'b000;

        // ALU and extension selects held steady for the whole EXE..WB span.
        if ((r_state == S_EXE) || (r_state == S_MEM) || (r_state == S_WB)) begin
            if (w_subu || w_beq) ALUOp = 3'b001;
            if (w_ori || w_lui) begin
                ALUOp  = 3'b010;
                AluSrc = 1'b1;
            end
            if (w_lui) LuiExt = 1'b1;
            if (w_lw || w_sw) begin
                AluSrc  = 1'b1;
                SignExt = 1'b1;
            end
            if (w_beq || w_bgtz) SignExt = 1'b1;
        end

        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
            end
            S_DCD: begin
                if (w_jal) begin
                    w_gpr_write = 1'b1;
                    RegDst      = 2'b10;
                    MemToReg    = 2'b10;
                    w_pc_write  = 1'b1;
                    NPCOp       = 2'b10;
                end else if (w_jr) begin
                    w_pc_write = 1'b1;
                    NPCOp      = 2'b11;
                end else if (!w_legal) begin
                    w_illegal = 1'b1;
                end
            end
            S_EXE: begin
                if (w_beq) begin
                    w_pc_write = zero;
                    NPCOp      = 2'b01;
                end else if (w_bgtz) begin
                    w_pc_write = gtz;
                    NPCOp      = 2'b01;
                end
            end
            S_MEM: begin
                w_dm_req   = 1'b1;
                w_dm_write = w_sw;
                w_mem_err  = w_timeout;
            end
            S_WB: begin
                w_gpr_write = 1'b1;
                if (w_rtype) RegDst = 2'b01;
                if (w_lw)    MemToReg = 2'b01;
            end
            default: ;
        endcase
    end

    assign PC_Write  = w_pc_write  & reset;
    assign IR_Write  = w_ir_write  & reset;
    assign GPR_Write = w_gpr_write & reset;
    assign DM_Write  = w_dm_write  & reset;
    assign dm_req    = w_dm_req    & reset;
    assign illegal   = w_illegal   & reset;
    assign mem_err   = w_mem_err   & reset;
    assign state     = r_state;

`ifdef INSTRET_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;

    assign w_retire = ((r_state == S_DCD) && (w_jal || w_jr))
                   || ((r_state == S_EXE) && (w_beq || w_bgtz))
                   || ((r_state == S_MEM) && w_sw && dm_ack)
                   ||  (r_state == S_WB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign instret = r_instret;
`else
    assign instret = '0;
`endif

endmodule
